// File: rtl/dac_seq_pkg.sv
// Shared types and helpers for the dac_seq waveform sequencer.
// Phase encoding and phase-ordering logic live here so every phase transition agrees.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRise = 2'd1,
        StHold = 2'd2,
        StFall = 2'd3
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // Phase following `cur`, skipping empty phases; after FALL either loop or stop.
    function automatic state_e next_phase(input state_e cur, input logic has_up,
                                          input logic has_hold, input logic has_down,
                                          input logic rep);
        state_e first;
        if (has_up) begin
            first = StRise;
        end else if (has_hold) begin
            first = StHold;
        end else if (has_down) begin
            first = StFall;
        end else begin
            first = StIdle;
        end
        next_phase = rep ? first : StIdle;
        case (cur)
            StIdle: next_phase = first;
            StRise: begin
                if (has_hold) begin
                    next_phase = StHold;
                end else if (has_down) begin
                    next_phase = StFall;
                end
            end
            StHold: begin
                if (has_down) begin
                    next_phase = StFall;
                end
            end
            default: ;
        endcase
    endfunction

endpackage

// File: rtl/dac_step_timer.sv
// Per-step divider: counts div..0, asserts tick at 0 and reloads itself.
module dac_step_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load || (cnt_q == '0)) begin
            cnt_q <= div;
        end else begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/dac_seq.sv
// Rise/hold/fall DAC waveform sequencer with step divider, repeat mode and status.
// The output register lags the phase state by one cycle.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_UP   = 16,
    parameter int unsigned MAX_DOWN = 16,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned DIV_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       set,
    input  logic                       repeat_mode,
    input  logic [MAX_UP*DATA_W-1:0]   up,
    input  logic [MAX_DOWN*DATA_W-1:0] down,
    input  logic [LEN_W-1:0]           up_len,
    input  logic [LEN_W-1:0]           down_len,
    input  logic [LEN_W-1:0]           hold_len,
    input  logic [DIV_W-1:0]           div,
    input  logic [DATA_W-1:0]          idle_val,
    output logic [DATA_W-1:0]          out,
    output logic                       busy,
    output logic                       done,
    output logic [LEN_W-1:0]           step_idx
);

    localparam int unsigned UP_IW = (MAX_UP > 1) ? $clog2(MAX_UP) : 1;
    localparam int unsigned DN_IW = (MAX_DOWN > 1) ? $clog2(MAX_DOWN) : 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    up_len_q, down_len_q, hold_len_q;
    logic [LEN_W-1:0]    idx_q, idx_d, cur_len;
    logic [DIV_W-1:0]    div_q, timer_div;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                busy_q, busy_d, done_q, done_d, set_q;
    logic                zero_pend_q, zero_pend_d;
    logic                trigger, tick, phase_end;
    logic [LEN_W-1:0]    up_len_c, down_len_c;
    logic [DATA_W-1:0]   up_arr [MAX_UP];
    logic [DATA_W-1:0]   down_arr [MAX_DOWN];

    for (genvar k = 0; k < MAX_UP; k++) begin : g_up
        assign up_arr[k] = up[k*DATA_W +: DATA_W];
    end
    for (genvar k = 0; k < MAX_DOWN; k++) begin : g_down
        assign down_arr[k] = down[k*DATA_W +: DATA_W];
    end

    assign up_len_c   = LEN_W'(clamp_len(32'(up_len), MAX_UP));
    assign down_len_c = LEN_W'(clamp_len(32'(down_len), MAX_DOWN));
    assign trigger    = en && (state_q == StIdle) && set && !set_q;
    assign timer_div  = trigger ? div : div_q;

    dac_step_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (trigger),
        .div  (timer_div),
        .tick (tick)
    );

    always_comb begin
        cur_len = '0;
        case (state_q)
            StRise:  cur_len = up_len_q;
            StHold:  cur_len = hold_len_q;
            StFall:  cur_len = down_len_q;
            default: cur_len = '0;
        endcase
    end

    assign phase_end = tick && (idx_q == cur_len - LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zero_pend_d = 1'b0;
        out_d       = out_q;
        if (!en) begin
            // Abort: silent return to idle, no completion pulse.
            state_d = StIdle;
            idx_d   = '0;
            busy_d  = 1'b0;
            out_d   = idle_val;
        end else begin
            case (state_q)
                StIdle: begin
                    out_d  = idle_val;
                    done_d = zero_pend_q;
                    if (trigger) begin
                        state_d     = next_phase(StIdle, up_len_c != '0, hold_len != '0,
                                                 down_len_c != '0, 1'b0);
                        zero_pend_d = (state_d == StIdle);
                    end
                end
                StRise: out_d = up_arr[UP_IW'(idx_q)];
                StHold: out_d = (up_len_q == '0) ? idle_val
                                                 : up_arr[UP_IW'(up_len_q - LEN_W'(1))];
                StFall: out_d = down_arr[DN_IW'(idx_q)];
                default: ;
            endcase
            if ((state_q != StIdle) && tick) begin
                if (phase_end) begin
                    state_d = next_phase(state_q, up_len_q != '0, hold_len_q != '0,
                                         down_len_q != '0, repeat_mode);
                    idx_d   = '0;
                    done_d  = (state_d == StIdle);
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            busy_d = (state_d != StIdle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            set_q       <= 1'b0;
            zero_pend_q <= 1'b0;
            up_len_q    <= '0;
            down_len_q  <= '0;
            hold_len_q  <= '0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            set_q       <= set;
            zero_pend_q <= zero_pend_d;
            if (trigger) begin
                up_len_q   <= up_len_c;
                down_len_q <= down_len_c;
                hold_len_q <= hold_len;
                div_q      <= div;
            end
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;

endmodule

// File: tb/tb_dac_seq.sv
// Directed self-checking bench for dac_seq: reset, profile, divider, clamp, repeat, abort.
module tb_dac_seq;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_UP   = 16;
    localparam int unsigned MAX_DOWN = 16;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned DIV_W    = 16;

    logic                       clk = 1'b0;
    logic                       rst_n, en, set, repeat_mode;
    logic [MAX_UP*DATA_W-1:0]   up;
    logic [MAX_DOWN*DATA_W-1:0] down;
    logic [LEN_W-1:0]           up_len, down_len, hold_len;
    logic [DIV_W-1:0]           div;
    logic [DATA_W-1:0]          idle_val;
    logic [DATA_W-1:0]          out;
    logic                       busy, done;
    logic [LEN_W-1:0]           step_idx;

    int checks = 0;
    int errors = 0;

    dac_seq #(
        .DATA_W  (DATA_W),
        .MAX_UP  (MAX_UP),
        .MAX_DOWN(MAX_DOWN),
        .LEN_W   (LEN_W),
        .DIV_W   (DIV_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .set        (set),
        .repeat_mode(repeat_mode),
        .up         (up),
        .down       (down),
        .up_len     (up_len),
        .down_len   (down_len),
        .hold_len   (hold_len),
        .div        (div),
        .idle_val   (idle_val),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising edge on set; returns just after the edge that detects it.
    task automatic fire();
        set = 1'b1;
        step();
        set = 1'b0;
    endtask

    task automatic load_basic(input logic [DIV_W-1:0] d);
        up          = '0;
        down        = '0;
        up[7:0]     = 8'd10;
        up[15:8]    = 8'd20;
        up[23:16]   = 8'd30;
        down[7:0]   = 8'd25;
        down[15:8]  = 8'd5;
        up_len      = 8'd3;
        hold_len    = 8'd2;
        down_len    = 8'd2;
        div         = d;
        idle_val    = 8'h80;
        repeat_mode = 1'b0;
    endtask

    task automatic test_reset();
        load_basic(16'd0);
        en = 1'b1;
        set = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: out=%h busy=%b done=%b idx=%0d want 00 0 0 0",
                     out, busy, done, step_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (out !== 8'h80 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: out=%h busy=%b want 80 0", out, busy);
        end
        fire();
        step();
        checks++;
        if (out !== 8'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_rise: out=%0d busy=%b want 10 1", out, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_rise: out=%h busy=%b done=%b idx=%0d want 00 0 0 0",
                     out, busy, done, step_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (out !== 8'h80 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: out=%h busy=%b done=%b want 80 0 0",
                     out, busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_out [8];
        logic [7:0] exp_idx [8];
        exp_out = '{8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 8'd25, 8'd5, 8'h80};
        exp_idx = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
        load_basic(16'd0);
        fire();
        checks++;
        if (busy !== 1'b1 || step_idx !== 8'd0 || out !== 8'h80) begin
            errors++;
            $display("FAIL basic_start: busy=%b idx=%0d out=%h want 1 0 80", busy, step_idx, out);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (out !== exp_out[k-1]) begin
                errors++;
                $display("FAIL basic_out[%0d]: got %0d want %0d", k, out, exp_out[k-1]);
            end
            checks++;
            if (busy !== (k < 7)) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got %b want %b", k, busy, (k < 7));
            end
            checks++;
            if (done !== (k == 7)) begin
                errors++;
                $display("FAIL basic_done[%0d]: got %b want %b", k, done, (k == 7));
            end
            checks++;
            if (step_idx !== exp_idx[k-1]) begin
                errors++;
                $display("FAIL basic_idx[%0d]: got %0d want %0d", k, step_idx, exp_idx[k-1]);
            end
        end
    endtask

    task automatic test_divider();
        logic [7:0] vals [7];
        logic [7:0] exp;
        int busy_cnt;
        int dones;
        vals = '{8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 8'd25, 8'd5};
        load_basic(16'd2);
        fire();
        busy_cnt = busy ? 1 : 0;
        dones = 0;
        for (int k = 1; k <= 22; k++) begin
            step();
            exp = (k <= 21) ? vals[(k-1)/3] : 8'h80;
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL div_out[%0d]: got %0d want %0d", k, out, exp);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (k != 21) begin
                    errors++;
                    $display("FAIL div_done_time: got cycle %0d want 21", k);
                end
            end
        end
        checks++;
        if (busy_cnt != 21) begin
            errors++;
            $display("FAIL div_busy_cycles: got %0d want 21", busy_cnt);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL div_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_zero_clamp();
        logic [7:0] exp;
        int busy_cnt;
        int dones;
        up = '0;
        down = '0;
        for (int i = 0; i < 16; i++) down[i*8 +: 8] = 8'h40 + 8'(i);
        up_len   = 8'd0;
        hold_len = 8'd0;
        down_len = 8'd20;
        div      = 16'd0;
        fire();
        busy_cnt = busy ? 1 : 0;
        dones = 0;
        for (int k = 1; k <= 18; k++) begin
            step();
            exp = (k <= 16) ? (8'h40 + 8'(k - 1)) : 8'h80;
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL clamp_out[%0d]: got %h want %h", k, out, exp);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (k != 16) begin
                    errors++;
                    $display("FAIL clamp_done_time: got cycle %0d want 16", k);
                end
            end
        end
        checks++;
        if (busy_cnt != 16 || dones != 1) begin
            errors++;
            $display("FAIL clamp_counts: busy=%0d done=%0d want 16 1", busy_cnt, dones);
        end
        down_len = 8'd0;
        fire();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_T: busy=%b done=%b want 0 0", busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || out !== 8'h80) begin
            errors++;
            $display("FAIL empty_T1: busy=%b done=%b out=%h want 0 1 80", busy, done, out);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_T2: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] p [7];
        logic [7:0] exp;
        int dones;
        p = '{8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 8'd25, 8'd5};
        load_basic(16'd0);
        repeat_mode = 1'b1;
        fire();
        dones = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp = (k <= 14) ? p[(k-1)%7] : 8'h80;
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL rep_out[%0d]: got %0d want %0d", k, out, exp);
            end
            checks++;
            if (busy !== (k < 14)) begin
                errors++;
                $display("FAIL rep_busy[%0d]: got %b want %b", k, busy, (k < 14));
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (k != 14) begin
                    errors++;
                    $display("FAIL rep_done_time: got cycle %0d want 14", k);
                end
            end
            if (k == 1) set = 1'b1;
            if (k == 2) set = 1'b0;
            if (k == 10) repeat_mode = 1'b0;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL rep_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_enable_abort();
        load_basic(16'd0);
        fire();
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (out !== 8'd25 || step_idx !== 8'd1) begin
            errors++;
            $display("FAIL abort_pre: out=%0d idx=%0d want 25 1", out, step_idx);
        end
        en = 1'b0;
        set = 1'b1;
        step();
        checks++;
        if (out !== 8'h80 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 8'd0) begin
            errors++;
            $display("FAIL abort_edge: out=%h busy=%b done=%b idx=%0d want 80 0 0 0",
                     out, busy, done, step_idx);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: done=%b busy=%b want 0 0", done, busy);
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_held_set[%0d]: busy=%b want 0", k, busy);
            end
        end
        set = 1'b0;
        step();
        fire();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_new_edge: busy=%b want 1", busy);
        end
        step();
        checks++;
        if (out !== 8'd10) begin
            errors++;
            $display("FAIL abort_restart_out: got %0d want 10", out);
        end
        for (int k = 0; k < 8; k++) step();
    endtask

    initial begin
        rst_n = 1'b1;
        en = 1'b1;
        set = 1'b0;
        repeat_mode = 1'b0;
        test_reset();
        test_basic();
        test_divider();
        test_zero_clamp();
        test_repeat();
        test_enable_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_seq.md
Name: dac_seq

Overview:
Parametrised waveform sequencer that drives an 8-bit (generic DATA_W) parallel DAC with a user-defined rise/hold/fall profile. It generalises the fixed 10+10-sample ramp generator in these ways:
- configurable sample depth
- per-step clock divider
- plateau hold phase
- repeat mode
- busy/done status

It sits between the control register block and the DAC output pins. One instance is used per output channel.

Parameters:
DATA_W, 8, sample width in bits
MAX_UP, 16, maximum rise samples
MAX_DOWN, 16, maximum fall samples
LEN_W, 8, width of the length fields
DIV_W, 16, width of the step-divider field

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  channel enable; 0 forces IDLE
set  in  1  trigger; rising edge starts a sequence
repeat  in  1  1 = loop rise/hold/fall while held high
up  in  MAX_UP*DATA_W  rise samples, sample k at [k*DATA_W +: DATA_W]
down  in  MAX_DOWN*DATA_W  fall samples, same packing
up_len  in  LEN_W  number of rise samples used
down_len  in  LEN_W  number of fall samples used
hold_len  in  LEN_W  plateau length in steps
div  in  DIV_W  each step lasts div+1 clk cycles
idle_val  in  DATA_W  output value when idle or disabled
out  out  DATA_W  registered DAC code
busy  out  1  high in RISE/HOLD/FALL
done  out  1  one-cycle pulse on sequence completion
step_idx  out  LEN_W  current sample index (debug)

Behaviour:
Reset (rst_n=0, asynchronous):
- state=IDLE, out=0, busy=0, done=0, step_idx=0, set_q=0.
- From the first clock after release, out=idle_val.

States and transitions:
- IDLE: out<=idle_val every cycle.
- Trigger: en=1 and set=1 with set_q=0 (set_q is set registered). On trigger:
  - Latch up_len, down_len, hold_len and div (clamped as below).
  - Go to the first non-empty phase of RISE, HOLD, FALL.
  - If all three lengths are 0: go straight back to IDLE and pulse done at T+1.
- Latency: trigger detected at edge T; out=up[0] is visible after edge T+1.
- Stepping: the timer counts div..0. Each sample is held div+1 cycles, then step_idx advances. div=0 gives one sample per clk.
- RISE: out=up[step_idx]. After sample up_len-1 completes, go to HOLD (or FALL if hold_len=0).
- HOLD: out keeps the last rise sample for hold_len steps. If up_len=0, out holds idle_val instead.
- FALL: out=down[step_idx]. After sample down_len-1 completes:
  - If repeat=1, go to RISE with step_idx=0.
  - Otherwise go to IDLE and pulse done in the same cycle the state enters IDLE.
- repeat is sampled only at the end of FALL. Dropping repeat mid-sequence finishes the current cycle.

Boundary conditions:
- Length clamping: up_len>MAX_UP is treated as MAX_UP; down_len>MAX_DOWN is treated as MAX_DOWN. The clamp is applied at latch.
- Retrigger: set edges while busy=1 are ignored; set_q still tracks set. A held-high set does not retrigger after completion; a new rising edge is required.
- en deasserted in any state: on the next edge, state=IDLE, out=idle_val, busy=0, no done pulse.
- en reasserted: a trigger needs a fresh set rising edge, evaluated with the current set_q.
- Config inputs changing mid-sequence: no effect; only the latched copies are used.
- step_idx is 0 in IDLE and resets to 0 at each phase entry.
- busy is registered and aligned with the state.

Decomposition:
- Shared include dac_seq_defs.vh:
  - state encodings ST_IDLE=2'd0, ST_RISE=2'd1, ST_HOLD=2'd2, ST_FALL=2'd3
  - a sample-select helper macro for the indexed part-select
- One sub-module, dac_step_timer:
  - loadable down-counter of width DIV_W
  - inputs: load, reload value div
  - output: tick, high when the count reaches 0, then auto-reload
  - used for all three phases
- Sample muxing and the FSM stay in dac_seq.

Test Plan:
1. Reset and idle: rst_n low mid-RISE with idle_val=8'h80, then release -> out=0 immediately, out=8'h80 one clk after release, busy=0, no done.
2. Basic profile: up_len=3 (10,20,30), hold_len=2, down_len=2 (25,5), div=0; set edge -> out sequence 10,20,30,30,30,25,5,idle; busy high 7 cycles; done pulse on the return to idle.
3. Divider: same profile with div=2 -> each value held exactly 3 cycles; busy high 21 cycles.
4. Zero and clamp: up_len=0, hold_len=0, down_len=20 with MAX_DOWN=16 -> goes straight to FALL, outputs exactly 16 samples; all lengths 0 -> done pulse at T+1, busy never set.
5. Repeat and retrigger: repeat=1 plus extra set pulses mid-RISE -> extra pulses ignored, profile loops; drop repeat during HOLD -> current FALL completes, single done pulse.
6. Enable abort: en=0 during FALL step 1 -> next edge out=idle_val, busy=0, no done; en=1 with set held high -> no start until a new set rising edge.
